// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH_A  = 10;
  localparam int DEF_WIDTH_B  = 8;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MULT_LAT = 1;
  localparam int CNT_W        = 16;

  // Saturating increment: a full counter stays pinned at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_grant.sv
// Round-robin one-hot grant: search begins one past the previous winner.
module rr_grant #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier among NUM_REQ requesters with round-robin grants.
// Optional per-requester transfer counters on grant_cnt when MULT_ARBITER_STATS_EN is defined.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH_A  = DEF_WIDTH_A,
  parameter int WIDTH_B  = DEF_WIDTH_B,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WIDTH_A-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH_B-1:0]    req_b,
  output logic                          mult_valid,
  output logic [WIDTH_A-1:0]            mult_a,
  output logic [WIDTH_B-1:0]            mult_b,
  input  logic [WIDTH_A+WIDTH_B-1:0]    mult_c,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH_A+WIDTH_B-1:0]    rsp_c,
  output logic                          busy
`ifdef MULT_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]      grant_cnt
`endif
);

  // state | meaning
  // IDLE  | no grants, nothing in flight
  // RUN   | granting one requester per cycle
  // DRAIN | grants stopped, waiting for in-flight products

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [NUM_REQ-1:0] grant;
  logic             transfer;
  logic [IDX_W-1:0] grant_idx;
  logic [WIDTH_A-1:0] sel_a;
  logic [WIDTH_B-1:0] sel_b;
  logic [MULT_LAT:0]  tag_vld;
  logic [IDX_W-1:0]   tag_idx [MULT_LAT+1];
  logic               in_flight;

  rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready  = (state == RUN) ? grant : '0;
  assign transfer   = |(req_valid & req_ready);
  assign in_flight  = |tag_vld;
  assign busy       = (state != IDLE) | in_flight;
  // Stage 0 of the tag pipeline is exactly the operand-valid cycle.
  assign mult_valid = tag_vld[0];

  always_comb begin
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_a     = req_a[i*WIDTH_A +: WIDTH_A];
        sel_b     = req_b[i*WIDTH_B +: WIDTH_B];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      mult_a     <= '0;
      mult_b     <= '0;
      tag_vld    <= '0;
      for (int k = 0; k <= MULT_LAT; k++) tag_idx[k] <= '0;
      rsp_valid  <= '0;
      rsp_c      <= '0;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN: begin
          if (en)             state <= RUN;
          else if (!in_flight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (transfer) begin
        mult_a     <= sel_a;
        mult_b     <= sel_b;
        last_grant <= grant_idx;
      end

      tag_vld[0] <= transfer;
      tag_idx[0] <= grant_idx;
      for (int k = 1; k <= MULT_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end

      // Last tag stage lines up with a valid mult_c; rsp_c holds otherwise.
      rsp_valid <= '0;
      if (tag_vld[MULT_LAT]) begin
        rsp_valid[tag_idx[MULT_LAT]] <= 1'b1;
        rsp_c                        <= mult_c;
      end
    end
  end

`ifdef MULT_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
    end else if (transfer) begin
      cnt[grant_idx] <= sat_inc(cnt[grant_idx]);
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: constant vectors, directed sequences and a queue-based reference model.
module tb_mult_arbiter;

  localparam int WA = 10;
  localparam int WB = 8;
  localparam int N  = 4;
  localparam int WC = WA + WB;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic            mult_valid;
  logic [WA-1:0]   mult_a;
  logic [WB-1:0]   mult_b;
  logic [WC-1:0]   mult_c;
  logic [N-1:0]    rsp_valid;
  logic [WC-1:0]   rsp_c;
  logic            busy;
`ifdef MULT_ARBITER_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  mult_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mult_valid (mult_valid),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_c     (mult_c),
    .rsp_valid  (rsp_valid),
    .rsp_c      (rsp_c),
    .busy       (busy)
`ifdef MULT_ARBITER_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle registered multiplier standing in for the real one.
  always_ff @(posedge clk) mult_c <= WC'(mult_a) * WC'(mult_b);

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: mode 0/1/2 = idle/run/drain, plus a queue of accepted operations.
  typedef struct {
    int          t;
    int          idx;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
  } op_t;

  op_t           ops[$];
  int            m_state;
  int            m_last;
  logic [WC-1:0] m_rsp_c;
  logic [WA-1:0] m_a;
  logic [WB-1:0] m_b;
  logic [N-1:0]  obs_ready;

  function automatic bit m_inflight(input int x);
    foreach (ops[i]) if (ops[i].t + 1 <= x && x <= ops[i].t + 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    ops.delete();
    m_state = 0;
    m_last  = N - 1;
    m_rsp_c = '0;
    m_a     = '0;
    m_b     = '0;
  endtask

  // Compare registered outputs for the current cycle against the model.
  task automatic model_check();
    logic [N-1:0] ev;
    bit           mv;
    ev = '0;
    mv = 1'b0;
    if (ops.size() > 0 && ops[0].t + 3 == cyc) begin
      ev[ops[0].idx] = 1'b1;
      m_rsp_c = WC'(ops[0].a) * WC'(ops[0].b);
      void'(ops.pop_front());
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_c", rsp_c, m_rsp_c);
    foreach (ops[i]) begin
      if (ops[i].t == cyc - 1) begin
        mv  = 1'b1;
        m_a = ops[i].a;
        m_b = ops[i].b;
      end
    end
    chk("mult_valid", mult_valid, mv);
    chk("mult_a", mult_a, m_a);
    chk("mult_b", mult_b, m_b);
    chk("busy", busy, (m_state != 0) || m_inflight(cyc));
  endtask

  // Drive one cycle of inputs, check req_ready, advance, then check registered outputs.
  task automatic step(input logic e, input logic [N-1:0] v,
                      input logic [N*WA-1:0] a, input logic [N*WB-1:0] b);
    int           g;
    logic [N-1:0] er;
    en        = e;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    g = -1;
    if (m_state == 1) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (g < 0 && v[p]) g = p;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", req_ready, er);
    if (g >= 0) begin
      ops.push_back('{t: cyc, idx: g, a: a[g*WA +: WA], b: b[g*WB +: WB]});
      m_last = g;
    end
    case (m_state)
      0: if (e) m_state = 1;
      1: if (!e) m_state = 2;
      default: begin
        if (e) m_state = 1;
        else if (!m_inflight(cyc)) m_state = 0;
      end
    endcase
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = '1;
    req_a     = '1;
    req_b     = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mult_valid", mult_valid, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    cyc++;
    model_reset();
    model_check();
  endtask

  function automatic logic [N*WA-1:0] rand_a();
    return (N*WA)'({$urandom(), $urandom()});
  endfunction

  function automatic logic [N*WB-1:0] rand_b();
    return (N*WB)'($urandom());
  endfunction

  typedef struct {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WC-1:0] c;
  } vec_t;

  vec_t          vt[6];
  int            order[6] = '{0, 1, 2, 3, 0, 1};
  logic [WC-1:0] got[$];
  int            nrsp;

  initial begin
    vt[0] = '{a: 10'd1023, b: 8'd255, c: 18'd260865};
    vt[1] = '{a: 10'd0,    b: 8'd200, c: 18'd0};
    vt[2] = '{a: 10'd1,    b: 8'd1,   c: 18'd1};
    vt[3] = '{a: 10'd512,  b: 8'd2,   c: 18'd1024};
    vt[4] = '{a: 10'd1000, b: 8'd100, c: 18'd100000};
    vt[5] = '{a: 10'd7,    b: 8'd13,  c: 18'd91};

    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    model_reset();
    do_reset();

    // Single requester 0, response three cycles after the transfer.
    step(1'b1, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b0001, (N*WA)'(vt[i].a), (N*WB)'(vt[i].b));
      step(1'b1, '0, '0, '0);
      step(1'b1, '0, '0, '0);
      chk("tbl_rsp_valid", rsp_valid, 4'b0001);
      chk("tbl_rsp_c", rsp_c, vt[i].c);
    end

    // All four requesters continuously valid.
    do_reset();
    step(1'b1, '0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'hF, rand_a(), rand_b());
      chk("rr_order", obs_ready, 64'(1) << order[k]);
    end
    for (int k = 0; k < 4; k++) step(1'b1, '0, '0, '0);

    // en falls while two operations are in flight.
    nrsp = 0;
    step(1'b1, 4'b0001, rand_a(), rand_b());
    step(1'b0, 4'b0010, rand_a(), rand_b());
    chk("drain_late_grant", obs_ready, 4'b0010);
    step(1'b0, 4'hF, rand_a(), rand_b());
    chk("drain_ready", obs_ready, 0);
    chk("drain_busy", busy, 1);
    if (rsp_valid != 0) nrsp++;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, '0, '0, '0);
      if (rsp_valid != 0) nrsp++;
    end
    chk("drain_rsp_count", nrsp, 2);
    chk("drain_idle_busy", busy, 0);
    step(1'b0, 4'hF, rand_a(), rand_b());
    chk("idle_ready", obs_ready, 0);

    // Reset one cycle after a transfer discards it.
    step(1'b1, '0, '0, '0);
    step(1'b1, 4'b0100, rand_a(), rand_b());
    chk("pre_rst_mult_valid", mult_valid, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, '0, '0, '0);
      chk("rst_discard", rsp_valid, 0);
    end
    step(1'b1, 4'hF, rand_a(), rand_b());
    chk("post_rst_grant", obs_ready, 4'b0001);
    for (int k = 0; k < 3; k++) step(1'b1, '0, '0, '0);

    // Requester 2 alone for five cycles, a=i, b=3.
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) step(1'b1, 4'b0100, (N*WA)'(i) << (2*WA), (N*WB)'(3) << (2*WB));
      else       step(1'b1, '0, '0, '0);
      if (rsp_valid == 4'b0100) got.push_back(rsp_c);
    end
    chk("req2_rsp_count", got.size(), 5);
    foreach (got[k]) chk("req2_rsp_c", got[k], 3 * k);

`ifdef MULT_ARBITER_STATS_EN
    do_reset();
    step(1'b1, '0, '0, '0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0010, rand_a(), rand_b());
    chk("cnt_slice0", grant_cnt[15:0], 0);
    chk("cnt_slice1", grant_cnt[31:16], 3);
    chk("cnt_slice2", grant_cnt[47:32], 0);
    chk("cnt_slice3", grant_cnt[63:48], 0);
    for (int k = 0; k < 3; k++) step(1'b1, '0, '0, '0);
`endif

    // Randomized traffic against the model, with one reset mid-stream.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, N'($urandom()), rand_a(), rand_b());
      if (n == 200) do_reset();
    end
    for (int k = 0; k < 6; k++) step(1'b0, '0, '0, '0);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_A, default 10, meaning operand-a width in bits.
REQ-002 The block SHALL have parameter WIDTH_B, default 8, meaning operand-b width in bits.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-004 The block SHALL have parameter MULT_LAT, default 1, meaning cycles from mult_valid/mult_a/mult_b to a valid mult_c.
REQ-005 The block SHALL use one clock and an asynchronous active-high reset, with ports as follows.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- en  in  1  enable new grants.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH_A  flattened operands a; requester i at [i*WIDTH_A +: WIDTH_A].
- req_b  in  NUM_REQ*WIDTH_B  flattened operands b; same packing as req_a.
- mult_valid  out  1  operand valid to multiplier.
- mult_a  out  WIDTH_A  operand a to multiplier.
- mult_b  out  WIDTH_B  operand b to multiplier.
- mult_c  in  WIDTH_A+WIDTH_B  product from multiplier.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_c  out  WIDTH_A+WIDTH_B  registered product.
- busy  out  1  high when not IDLE or any operation is in flight.

Function
REQ-006 The block SHALL implement an FSM with states IDLE, RUN and DRAIN.
- IDLE->RUN when en=1.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1.
- DRAIN->IDLE when en=0 and no operation is in flight.
REQ-007 The block SHALL grant only in RUN, at most one requester per cycle, giving throughput of one operation per cycle.
REQ-008 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ, and last_grant updates only on a transfer.
REQ-009 req_ready[i] SHALL be combinational, high only for the granted requester in the current cycle; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 A transfer in cycle T SHALL register the operands so that mult_valid=1 and mult_a/mult_b hold them in cycle T+1; mult_valid SHALL be 0 otherwise.
REQ-011 The block SHALL carry the requester index through a tag pipeline of depth MULT_LAT+1 aligned with mult_c.
REQ-012 The block SHALL sample mult_c in cycle T+1+MULT_LAT and drive rsp_valid[tag]=1 with rsp_c=mult_c in cycle T+2+MULT_LAT (T+3 at default).
REQ-013 Responses SHALL NOT be backpressured; every accepted operation SHALL produce exactly one single-cycle response, in issue order.
REQ-014 rsp_c SHALL hold its last value when rsp_valid is all zero.
REQ-015 When en falls in the same cycle as a grant, that transfer SHALL complete and be drained.
REQ-016 A requester that deasserts req_valid before a grant SHALL lose nothing; its request is simply not transferred.

Reset
REQ-017 rst SHALL asynchronously force all of the following:
- state IDLE;
- last_grant = NUM_REQ-1, so requester 0 has first priority;
- tag pipeline cleared;
- req_ready, mult_valid, mult_a, mult_b, rsp_valid, rsp_c and busy all zero.
REQ-018 Operations in flight at reset SHALL be discarded with no response.

Configuration
REQ-019 With macro MULT_ARBITER_STATS_EN defined, the block SHALL add output grant_cnt (NUM_REQ*16 bits), holding a per-requester saturating count of transfers, cleared by rst.
REQ-020 Without MULT_ARBITER_STATS_EN, grant_cnt and its counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 Package mult_arbiter_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN), the default widths and the counter width constant 16.
REQ-022 Round-robin selection SHALL be a sub-module rr_grant with inputs req and last_grant and output grant (one-hot); the FSM, the tag pipeline and the response register SHALL stay in mult_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios, using the existing multiplier as mult, at default parameters:
- req0 alone, a=1023, b=255, en=1 -> rsp_valid=4'b0001, rsp_c=260865 three cycles after transfer.
- All four requesters valid continuously -> grant order 0,1,2,3,0,1; one response per cycle after fill; each rsp_c correct.
- en dropped with 2 operations in flight -> state DRAIN, req_ready=0, both responses delivered, then IDLE with busy=0.
- rst pulsed one cycle after a transfer -> no rsp_valid for that operation; all outputs 0; the next grant goes to req0.
- req2 valid alone for 5 cycles with a=i, b=3 -> 5 consecutive responses with rsp_c=0,3,6,9,12.
- With MULT_ARBITER_STATS_EN, 3 req1 transfers -> grant_cnt slice 1 = 3; other slices 0.
